// File: rtl/hack_cpu_ws.sv
// hack_cpu_ws: 16-bit Hack-style CPU core with instruction bubbles and data-memory wait states.
// Define HACK_CPU_HALT_EN to add the HALT state and the halted output (self-jump stops the core).
module hack_cpu_ws #(
  parameter int unsigned     ADDR_W       = 15,
  parameter int unsigned     PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instruction,
  input  logic              instr_valid,
  input  logic [15:0]       inM,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] addressM,
  output logic              readM,
  output logic              writeM,
  output logic [15:0]       outM,
  output logic [PC_W-1:0]   pc,
  output logic              stall,
`ifdef HACK_CPU_HALT_EN
  output logic              halted,
`endif
  output logic [1:0]        dbg_state
);

  // Handshakes: an instruction is consumed only while instr_valid=1 in RUN; a memory
  // access (readM|writeM) completes on the cycle mem_ready=1, otherwise the core holds the
  // access stable in WAIT_MEM with stall=1 until mem_ready=1 is seen.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1
`ifdef HACK_CPU_HALT_EN
    ,
    HALT     = 2'd2
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     a_reg, d_reg, ir;
  logic [PC_W-1:0] pc_reg;

  logic [15:0] cur;
  logic        active, is_c, a_sel, d_a, d_d, d_m;
  logic [15:0] x0, x1, y0, y1, alu_raw, alu_out;
  logic        zr, ng, taken, mem_acc, commit;
`ifdef HACK_CPU_HALT_EN
  logic        self_jump;
`endif

  // Decode, ALU and handshake control. In WAIT_MEM the latched word replaces the input.
  always_comb begin
    cur     = (state == WAIT_MEM) ? ir : instruction;
    active  = !rst && ((state == WAIT_MEM) || (state == RUN && instr_valid));
    is_c    = cur[15];
    a_sel   = cur[12];
    d_a     = cur[5];
    d_d     = cur[4];
    d_m     = cur[3];
    x0      = cur[11] ? 16'd0 : d_reg;
    x1      = cur[10] ? ~x0 : x0;
    y0      = cur[9] ? 16'd0 : (a_sel ? inM : a_reg);
    y1      = cur[8] ? ~y0 : y0;
    alu_raw = cur[7] ? (x1 + y1) : (x1 & y1);
    alu_out = cur[6] ? ~alu_raw : alu_raw;
    zr      = (alu_out == 16'd0);
    ng      = alu_out[15];
    taken   = is_c && ((cur[2] && ng) || (cur[1] && zr) || (cur[0] && !ng && !zr));
    readM   = active && is_c && a_sel;
    writeM  = active && is_c && d_m;
    mem_acc = readM || writeM;
    stall   = mem_acc && !mem_ready;
    commit  = active && !stall;
  end

`ifdef HACK_CPU_HALT_EN
  assign self_jump = taken && (a_reg[PC_W-1:0] == pc_reg);
  assign halted    = (state == HALT);
`endif

  always_comb begin
    state_nxt = state;
    if (stall) begin
      state_nxt = WAIT_MEM;
    end else if (commit) begin
`ifdef HACK_CPU_HALT_EN
      state_nxt = self_jump ? HALT : RUN;
`else
      state_nxt = RUN;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Architectural registers change only on commit; addressM and the jump target see A_old.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      d_reg  <= '0;
      ir     <= '0;
      pc_reg <= RESET_VECTOR;
    end else begin
      if (stall) ir <= cur;
      if (commit) begin
        if (!is_c) begin
          a_reg <= {1'b0, cur[14:0]};
        end else begin
          if (d_a) a_reg <= {1'b0, alu_out[14:0]};
          if (d_d) d_reg <= alu_out;
        end
        pc_reg <= taken ? a_reg[PC_W-1:0] : pc_reg + PC_W'(1);
      end
    end
  end

  assign addressM  = a_reg[ADDR_W-1:0];
  assign outM      = alu_out;
  assign pc        = pc_reg;
  assign dbg_state = state;

endmodule

// File: tb/tb_hack_cpu_ws.sv
// Self-checking bench for hack_cpu_ws: directed scenarios plus randomized run against a mnemonic-level model.
// Builds with or without HACK_CPU_HALT_EN.
module tb_hack_cpu_ws;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, instr_valid, mem_ready, readM, writeM, stall;
  logic [15:0] instruction, inM, outM, pc;
  logic [14:0] addressM;
  logic [1:0]  dbg_state;
`ifdef HACK_CPU_HALT_EN
  logic        halted;
`endif

  logic        s_rst, s_valid, s_ready, s_readM, s_writeM, s_stall;
  logic [15:0] s_instr, s_inM, s_outM;
  logic [7:0]  s_addr;
  logic [3:0]  s_pc;
  logic [1:0]  s_dbg;
`ifdef HACK_CPU_HALT_EN
  logic        s_halted;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_a, m_d, m_pc, m_ir;
  logic        m_wait, m_halt;
  logic [5:0]  comp_tab [18];

  hack_cpu_ws #(.ADDR_W(15), .PC_W(16), .RESET_VECTOR(16'd0)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .inM(inM), .mem_ready(mem_ready), .addressM(addressM), .readM(readM),
    .writeM(writeM), .outM(outM), .pc(pc), .stall(stall),
`ifdef HACK_CPU_HALT_EN
    .halted(halted),
`endif
    .dbg_state(dbg_state)
  );

  hack_cpu_ws #(.ADDR_W(8), .PC_W(4), .RESET_VECTOR(4'd13)) dut_small (
    .clk(clk), .rst(s_rst), .instruction(s_instr), .instr_valid(s_valid),
    .inM(s_inM), .mem_ready(s_ready), .addressM(s_addr), .readM(s_readM),
    .writeM(s_writeM), .outM(s_outM), .pc(s_pc), .stall(s_stall),
`ifdef HACK_CPU_HALT_EN
    .halted(s_halted),
`endif
    .dbg_state(s_dbg)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] ins, input logic v, input logic [15:0] im, input logic r);
    instruction = ins;
    instr_valid = v;
    inM         = im;
    mem_ready   = r;
  endtask

  task automatic reset_main();
    rst = 1'b1;
    drive(16'h0000, 1'b0, 16'h0000, 1'b1);
    tick();
    rst = 1'b0;
  endtask

  // Hack comp mnemonics as plain arithmetic on D and y (y = A or M).
  function automatic logic [15:0] hack_eval(input logic [5:0] comp, input logic [15:0] d, input logic [15:0] y);
    logic [15:0] r;
    case (comp)
      6'b101010: r = 16'd0;
      6'b111111: r = 16'd1;
      6'b111010: r = 16'hFFFF;
      6'b001100: r = d;
      6'b110000: r = y;
      6'b001101: r = ~d;
      6'b110001: r = ~y;
      6'b001111: r = 16'd0 - d;
      6'b110011: r = 16'd0 - y;
      6'b011111: r = d + 16'd1;
      6'b110111: r = y + 16'd1;
      6'b001110: r = d - 16'd1;
      6'b110010: r = y - 16'd1;
      6'b000010: r = d + y;
      6'b010011: r = d - y;
      6'b000111: r = y - d;
      6'b000000: r = d & y;
      6'b010101: r = d | y;
      default:   r = 16'hxxxx;
    endcase
    return r;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(16'hEA90, 1'b1, 16'h1234, 1'b1);
    tick();
    tick();
    checks++; if (pc !== 16'd0) begin failures++; $display("FAIL reset_pc: got %0d want 0", pc); end
    checks++; if (addressM !== 15'd0) begin failures++; $display("FAIL reset_a: got %0d want 0", addressM); end
    drive(16'hF4C8, 1'b1, 16'h1234, 1'b0);
    #1;
    checks++; if ({readM, writeM, stall} !== 3'b000) begin failures++; $display("FAIL reset_ctrl: got %b want 000", {readM, writeM, stall}); end
    rst = 1'b0;
    drive(16'hE300, 1'b0, 16'h0000, 1'b1);
    #1;
    checks++; if (outM !== 16'd0) begin failures++; $display("FAIL reset_d: got %0d want 0", outM); end
    drive(16'h0007, 1'b1, 16'h0000, 1'b1);
    tick();
    checks++; if (pc !== 16'd1) begin failures++; $display("FAIL reset_release_pc: got %0d want 1", pc); end
    checks++; if (addressM !== 15'd7) begin failures++; $display("FAIL reset_release_a: got %0d want 7", addressM); end
  endtask

  task automatic prefix_a_to_d();
    reset_main();
    drive(16'd16514, 1'b1, 16'h0000, 1'b1);
    tick();
    drive(16'hEC10, 1'b1, 16'h0000, 1'b1);
    tick();
  endtask

  task automatic test_mem_write();
    prefix_a_to_d();
    checks++; if (pc !== 16'd2) begin failures++; $display("FAIL mw_prefix_pc: got %0d want 2", pc); end
    drive(16'hF4C8, 1'b1, 16'd27654, 1'b1);
    #1;
    checks++; if (addressM !== 15'd16514) begin failures++; $display("FAIL mw_addr: got %0d want 16514", addressM); end
    checks++; if ({readM, writeM, stall} !== 3'b110) begin failures++; $display("FAIL mw_ctrl: got %b want 110", {readM, writeM, stall}); end
    checks++; if (outM !== 16'hD47C) begin failures++; $display("FAIL mw_outM: got %h want d47c", outM); end
    tick();
    checks++; if (pc !== 16'd3) begin failures++; $display("FAIL mw_pc: got %0d want 3", pc); end
    drive(16'hE300, 1'b0, 16'h0000, 1'b1);
    #1;
    checks++; if (outM !== 16'd16514) begin failures++; $display("FAIL mw_d: got %0d want 16514", outM); end
  endtask

  task automatic test_wait_states();
    prefix_a_to_d();
    drive(16'hF4C8, 1'b1, 16'd27654, 1'b0);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ws_stall0: got %b want 1", stall); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), (i == 1) ? 16'd100 : 16'd27654, 1'b0);
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ws_stall: cycle %0d got %b want 1", i, stall); end
      checks++; if (pc !== 16'd2) begin failures++; $display("FAIL ws_pc: cycle %0d got %0d want 2", i, pc); end
      checks++; if ({addressM, readM, writeM} !== {15'd16514, 2'b11}) begin failures++; $display("FAIL ws_hold: got %0d %b%b want 16514 11", addressM, readM, writeM); end
      checks++; if (outM !== ((i == 1) ? 16'd16414 : 16'hD47C)) begin failures++; $display("FAIL ws_outM: cycle %0d got %h", i, outM); end
      tick();
    end
    drive(16'($urandom_range(0, 65535)), 1'b0, 16'd27654, 1'b1);
    #1;
    checks++; if ({stall, writeM} !== 2'b01) begin failures++; $display("FAIL ws_release: got %b want 01", {stall, writeM}); end
    tick();
    checks++; if (pc !== 16'd3) begin failures++; $display("FAIL ws_commit_pc: got %0d want 3", pc); end
    drive(16'hE300, 1'b0, 16'h0000, 1'b1);
    #1;
    checks++; if (outM !== 16'd16514) begin failures++; $display("FAIL ws_d_kept: got %0d want 16514", outM); end
    // A memory instruction that would write D is abandoned by reset while waiting.
    prefix_a_to_d();
    drive(16'hF4D8, 1'b1, 16'd27654, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(16'hE300, 1'b0, 16'h0000, 1'b1);
    #1;
    checks++; if ({pc, stall, outM} !== {16'd0, 1'b0, 16'd0}) begin failures++; $display("FAIL ws_reset_abandon: pc=%0d stall=%b d=%0d want 0 0 0", pc, stall, outM); end
  endtask

  task automatic test_jump();
    prefix_a_to_d();
    drive(16'd324, 1'b1, 16'h0000, 1'b1);
    tick();
    drive(16'hF1C5, 1'b1, 16'd350, 1'b1);
    #1;
    checks++; if (outM !== 16'hC0DC) begin failures++; $display("FAIL jmp_out: got %h want c0dc", outM); end
    checks++; if ({readM, writeM} !== 2'b10) begin failures++; $display("FAIL jmp_ctrl: got %b want 10", {readM, writeM}); end
    tick();
    checks++; if (pc !== 16'd324) begin failures++; $display("FAIL jmp_taken_pc: got %0d want 324", pc); end
    drive(16'hF1C2, 1'b1, 16'd350, 1'b1);
    tick();
    checks++; if (pc !== 16'd325) begin failures++; $display("FAIL jmp_not_taken_pc: got %0d want 325", pc); end
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 2; i++) begin
      drive(16'hF4D8, 1'b0, 16'($urandom_range(0, 65535)), 1'b0);
      #1;
      checks++; if ({readM, writeM, stall} !== 3'b000) begin failures++; $display("FAIL bub_ctrl: got %b want 000", {readM, writeM, stall}); end
      tick();
    end
    checks++; if ({pc, addressM} !== {16'd325, 15'd324}) begin failures++; $display("FAIL bub_hold: pc=%0d a=%0d want 325 324", pc, addressM); end
    drive(16'hE300, 1'b0, 16'h0000, 1'b1);
    #1;
    checks++; if (outM !== 16'd16514) begin failures++; $display("FAIL bub_d: got %0d want 16514", outM); end
  endtask

  task automatic test_wrap();
    s_rst = 1'b1; s_instr = 16'h0000; s_valid = 1'b0; s_inM = 16'h0000; s_ready = 1'b1;
    tick();
    s_rst = 1'b0;
    checks++; if (s_pc !== 4'd13) begin failures++; $display("FAIL wrap_reset_vector: got %0d want 13", s_pc); end
    s_instr = 16'h1234; s_valid = 1'b1;
    tick();
    checks++; if ({s_pc, s_addr} !== {4'd14, 8'h34}) begin failures++; $display("FAIL wrap_addr: pc=%0d a=%h want 14 34", s_pc, s_addr); end
    s_instr = 16'h0050;
    tick();
    s_instr = 16'h0123;
    tick();
    checks++; if (s_pc !== 4'd0) begin failures++; $display("FAIL wrap_pc: got %0d want 0", s_pc); end
    s_instr = 16'hEA87;
    tick();
    checks++; if (s_pc !== 4'd3) begin failures++; $display("FAIL wrap_jump_target: got %0d want 3", s_pc); end
  endtask

  task automatic test_self_jump();
    reset_main();
    for (int i = 0; i < 4; i++) begin
      drive(16'h0000, 1'b1, 16'h0000, 1'b1);
      tick();
    end
    drive(16'd5, 1'b1, 16'h0000, 1'b1);
    tick();
    drive(16'hEA87, 1'b1, 16'h0000, 1'b1);
    tick();
`ifdef HACK_CPU_HALT_EN
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_enter: got %b want 1", halted); end
    for (int i = 0; i < 10; i++) begin
      drive(16'($urandom_range(0, 65535)), 1'b1, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      #1;
      checks++; if ({pc, readM, writeM, stall} !== {16'd5, 3'b000}) begin failures++; $display("FAIL halt_hold: pc=%0d ctrl=%b want 5 000", pc, {readM, writeM, stall}); end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({halted, pc} !== {1'b0, 16'd0}) begin failures++; $display("FAIL halt_exit: halted=%b pc=%0d want 0 0", halted, pc); end
`else
    for (int i = 0; i < 3; i++) begin
      checks++; if (pc !== 16'd5) begin failures++; $display("FAIL selfjmp_pc: got %0d want 5", pc); end
      tick();
    end
`endif
  endtask

  task automatic test_random();
    logic [15:0] cur, res, old_a, old_pc;
    logic        act, e_rd, e_wr, e_st, taken;
    reset_main();
    m_a = 16'd0; m_d = 16'd0; m_pc = 16'd0; m_ir = 16'd0; m_wait = 1'b0; m_halt = 1'b0;
    for (int n = 0; n < 600; n++) begin
`ifdef HACK_CPU_HALT_EN
      checks++; if (halted !== m_halt) begin failures++; $display("FAIL rnd_halted: n=%0d got %b want %b", n, halted, m_halt); end
`endif
      if (m_halt) begin
        reset_main();
        m_a = 16'd0; m_d = 16'd0; m_pc = 16'd0; m_wait = 1'b0; m_halt = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) instruction = 16'($urandom_range(0, 32767));
      else instruction = {3'b111, 1'($urandom_range(0, 1)), comp_tab[$urandom_range(0, 17)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      instr_valid = ($urandom_range(0, 4) != 0);
      inM         = 16'($urandom_range(0, 65535));
      mem_ready   = ($urandom_range(0, 2) != 0);
      #1;
      cur  = m_wait ? m_ir : instruction;
      act  = m_wait || instr_valid;
      e_rd = act && cur[15] && cur[12];
      e_wr = act && cur[15] && cur[3];
      e_st = (e_rd || e_wr) && !mem_ready;
      res  = hack_eval(cur[11:6], m_d, cur[12] ? inM : m_a);
      checks++; if ({readM, writeM, stall} !== {e_rd, e_wr, e_st}) begin failures++; $display("FAIL rnd_ctrl: n=%0d got %b want %b", n, {readM, writeM, stall}, {e_rd, e_wr, e_st}); end
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc: n=%0d got %0d want %0d", n, pc, m_pc); end
      checks++; if (addressM !== m_a[14:0]) begin failures++; $display("FAIL rnd_addr: n=%0d got %0d want %0d", n, addressM, m_a[14:0]); end
      if (act && cur[15]) begin
        checks++; if (outM !== res) begin failures++; $display("FAIL rnd_outM: n=%0d got %h want %h", n, outM, res); end
      end
      tick();
      if (e_st) begin
        m_wait = 1'b1;
        m_ir   = cur;
      end else if (act) begin
        old_a  = m_a;
        old_pc = m_pc;
        taken  = 1'b0;
        if (!cur[15]) begin
          m_a = {1'b0, cur[14:0]};
        end else begin
          taken = (cur[2] && $signed(res) < 0) || (cur[1] && res == 16'd0) || (cur[0] && $signed(res) > 0);
          if (cur[5]) m_a = {1'b0, res[14:0]};
          if (cur[4]) m_d = res;
        end
        m_pc   = taken ? old_a : old_pc + 16'd1;
        m_wait = 1'b0;
`ifdef HACK_CPU_HALT_EN
        if (taken && old_a == old_pc) m_halt = 1'b1;
`endif
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    comp_tab = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                 6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                 6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
    rst = 1'b1;
    s_rst = 1'b1; s_instr = 16'h0000; s_valid = 1'b0; s_inM = 16'h0000; s_ready = 1'b1;
    drive(16'h0000, 1'b0, 16'h0000, 1'b1);
    test_reset();
    test_mem_write();
    test_wait_states();
    test_jump();
    test_bubble();
    test_wrap();
    test_self_jump();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
